jt1943_scan2x: RTL and testbench
================================

# jt1943_scan2x

Line doubler on the video path directly downstream of the 1943 game top. Captures each 15 kHz input line (4-bit RGB plus blanking) at the 6 MHz pixel enable into one of two ping-pong line buffers, and replays the previous line twice at the 12 MHz enable, producing a 31 kHz progressive signal with regenerated horizontal sync and pass-through vertical sync. Pure single-clock design driven by the game clock and its clock enables.

## Interface
- AW, 9, line-buffer address width; maximum captured line length 2^AW-1 pixels
- HS_POL, 1, polarity of input and output HS (1 = active-high)

- clk  in  1  game clock (24 or 12 MHz)
- rst  in  1  reset; synchronous, active-high
- cen6  in  1  input pixel enable
- cen12  in  1  output pixel enable; every cen6 tick is also a cen12 tick
- red, green, blue  in  4 each  game colour
- LHBL, LVBL  in  1 each  active-low horizontal/vertical blanking
- HS, VS  in  1 each  game syncs
- vga_red, vga_green, vga_blue  out  4 each  doubled colour
- vga_hs, vga_vs  out  1 each  doubled syncs
- vga_blank  out  1  high when doubled pixel is blanked

## Operation
- Two buffers B0/B1, each 2^AW words of 13 bits {blank, R, G, B}; blank = ~(LHBL & LVBL). Write buffer index wsel; read buffer is ~wsel.
- Write side, on each cen6: store pixel at wr_addr in buffer wsel; wr_addr increments, saturating at 2^AW-1 (excess pixels overwrite last word, no wrap).
- Input HS active edge (sampled on cen6, edge = active now, inactive previous cen6): latch line_len <= wr_addr, latch hs_len <= count of cen6 ticks HS was active in the previous pulse (saturating, AW bits), latch vs_line <= VS, toggle wsel, clear wr_addr, clear rd_addr, clear half.
- Read side, on each cen12: read buffer ~wsel at rd_addr; rd_addr increments; when rd_addr = line_len-1 it returns to 0 and half toggles (second replay). After second replay completes and before next swap, rd_addr holds at 0 and output is forced blank.
- vga_hs active while rd_addr < hs_len within each replay; vga_vs = vs_line (polarity of VS unchanged).
- line_len = 0 (no line captured yet, or two HS edges with no cen6 between): output forced blank, vga_hs inactive.
- Simultaneous HS edge and rd_addr wrap: swap wins; replay restarts at 0 of the new buffer with half=0.
- Mid-frame reset: all state cleared on the next clk; first valid output line appears one full input line after the first HS edge following reset release.

## Timing
- Reset values: vga_red/green/blue = 0, vga_hs = ~HS_POL (inactive), vga_vs = 0, vga_blank = 1, wsel = 0, wr_addr = rd_addr = line_len = hs_len = 0, half = 0.
- Buffer read is registered: data for rd_addr k presented on cen12 tick t appears on outputs after the clk edge of cen12 tick t+1 (one cen12 of latency); vga_hs/vga_vs/vga_blank delayed identically so all outputs stay aligned.
- Line latency: input line n is output during input line n+1, starting 2 clk edges after the cen6 tick detecting the HS edge.
- Output line period = line_len cen12 ticks = half input line period when cen12 rate is exactly 2x cen6.
- Outputs change only on clk edges following cen12; hold otherwise.

## Test plan
- Reset: assert rst 3 clk mid-line -> all outputs at reset values on next edge, vga_blank=1 until a full line captured and one HS edge later.
- Nominal line: 384 cen6 pixels, HS active 32 cen6, pixel value = address[11:0] -> two output replays of 384 cen12 each with identical pixel sequence 0..383, vga_hs active for first 32 cen12 of each replay.
- Blanking: LHBL low for pixels 0..63 -> vga_blank=1 on output addresses 0..63 in both replays, 0 elsewhere.
- Overflow: 600 pixels between HS edges with AW=9 -> line_len=511, word 511 holds pixel 599, no wrap corruption of words 0..510.
- Short line then swap on wrap: line_len=10, HS edge coincident with rd_addr=9 -> next output pixel read is address 0 of new buffer, half=0.
- VS: VS asserted during input line n -> vga_vs asserted for both replays of line n (output during line n+1), deasserted one input line after VS drops.

Source files
------------

// File: rtl/jt1943_scan2x.sv
// Line doubler: captures 15 kHz lines at cen6 into ping-pong buffers and
// replays each stored line twice at cen12 with regenerated HS.
module jt1943_scan2x #(
    parameter int AW     = 9,
    parameter bit HS_POL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen6,
    input  logic       cen12,
    input  logic [3:0] red,
    input  logic [3:0] green,
    input  logic [3:0] blue,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic       HS,
    input  logic       VS,
    output logic [3:0] vga_red,
    output logic [3:0] vga_green,
    output logic [3:0] vga_blue,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank
);
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        RD_FIRST,
        RD_SECOND,
        RD_DONE
    } rd_state_t;

    logic [12:0] buf0 [DEPTH];
    logic [12:0] buf1 [DEPTH];

    logic          wsel_q, wsel_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] line_len_q, line_len_d;
    logic [AW-1:0] hs_len_q, hs_len_d;
    logic [AW-1:0] hs_cnt_q, hs_cnt_d;
    logic          hs_prev_q, hs_prev_d;
    logic          vs_line_q, vs_line_d;
    logic          armed_q, armed_d;
    rd_state_t     rd_state_q, rd_state_d;

    logic [12:0]   rdata_q;
    logic          s1_force_q, s1_hs_q, s1_vs_q;
    logic [11:0]   out_rgb_q;
    logic          out_hs_q, out_vs_q, out_blank_q;

    logic          hs_in_act, hs_edge, wr_buf, rd_force, rd_last;
    logic [AW-1:0] wr_ptr;
    logic [12:0]   pix_word;

    assign hs_in_act = (HS == HS_POL);
    assign hs_edge   = cen6 & hs_in_act & ~hs_prev_q;
    assign pix_word  = {~(LHBL & LVBL), red, green, blue};
    // The pixel sampled on the HS edge tick is pixel 0 of the new line,
    // so it goes straight into the buffer that becomes the write side.
    assign wr_buf    = hs_edge ? ~wsel_q : wsel_q;
    assign wr_ptr    = hs_edge ? '0 : wr_addr_q;
    assign rd_force  = (line_len_q == '0) | (rd_state_q == RD_DONE);
    assign rd_last   = (rd_addr_q == line_len_q - AW'(1));

    always_comb begin
        wsel_d     = wsel_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        line_len_d = line_len_q;
        hs_len_d   = hs_len_q;
        hs_cnt_d   = hs_cnt_q;
        hs_prev_d  = hs_prev_q;
        vs_line_d  = vs_line_q;
        armed_d    = armed_q;
        rd_state_d = rd_state_q;

        if (cen6) begin
            hs_prev_d = hs_in_act;
            wr_addr_d = (wr_ptr == '1) ? wr_ptr : wr_ptr + AW'(1);
            if (hs_in_act && hs_cnt_q != '1) begin
                hs_cnt_d = hs_cnt_q + AW'(1);
            end
        end

        if (cen12) begin
            if (rd_force) begin
                rd_addr_d = '0;
            end else if (rd_last) begin
                rd_addr_d  = '0;
                rd_state_d = (rd_state_q == RD_FIRST) ? RD_SECOND : RD_DONE;
            end else begin
                rd_addr_d = rd_addr_q + AW'(1);
            end
        end

        // Swap has priority over a coincident replay wrap.
        if (hs_edge) begin
            hs_cnt_d   = AW'(1);
            hs_len_d   = hs_cnt_q;
            line_len_d = armed_q ? wr_addr_q : '0;
            armed_d    = 1'b1;
            vs_line_d  = VS;
            wsel_d     = ~wsel_q;
            rd_addr_d  = '0;
            rd_state_d = RD_FIRST;
        end
    end

    always_ff @(posedge clk) begin
        if (cen6) begin
            if (wr_buf) buf1[wr_ptr] <= pix_word;
            else        buf0[wr_ptr] <= pix_word;
        end
        if (cen12) begin
            rdata_q <= wsel_q ? buf0[rd_addr_q] : buf1[rd_addr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wsel_q      <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            line_len_q  <= '0;
            hs_len_q    <= '0;
            hs_cnt_q    <= '0;
            hs_prev_q   <= 1'b0;
            vs_line_q   <= 1'b0;
            armed_q     <= 1'b0;
            rd_state_q  <= RD_FIRST;
            s1_force_q  <= 1'b1;
            s1_hs_q     <= 1'b0;
            s1_vs_q     <= 1'b0;
            out_rgb_q   <= '0;
            out_hs_q    <= ~HS_POL;
            out_vs_q    <= 1'b0;
            out_blank_q <= 1'b1;
        end else begin
            wsel_q     <= wsel_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            line_len_q <= line_len_d;
            hs_len_q   <= hs_len_d;
            hs_cnt_q   <= hs_cnt_d;
            hs_prev_q  <= hs_prev_d;
            vs_line_q  <= vs_line_d;
            armed_q    <= armed_d;
            rd_state_q <= rd_state_d;
            if (cen12) begin
                s1_force_q  <= rd_force;
                s1_hs_q     <= ~rd_force & (rd_addr_q < hs_len_q);
                s1_vs_q     <= vs_line_q;
                out_rgb_q   <= s1_force_q ? '0 : rdata_q[11:0];
                out_blank_q <= s1_force_q | rdata_q[12];
                out_hs_q    <= s1_hs_q ? HS_POL : ~HS_POL;
                out_vs_q    <= s1_vs_q;
            end
        end
    end

    assign vga_red   = out_rgb_q[11:8];
    assign vga_green = out_rgb_q[7:4];
    assign vga_blue  = out_rgb_q[3:0];
    assign vga_hs    = out_hs_q;
    assign vga_vs    = out_vs_q;
    assign vga_blank = out_blank_q;

endmodule

// File: tb/tb_jt1943_scan2x.sv
// Scoreboard bench for jt1943_scan2x: a line-level model predicts one output
// word per cen12 tick; a monitor pops and compares after every cen12 edge.
module tb_jt1943_scan2x;
    localparam int AW     = 9;
    localparam bit HS_POL = 1'b1;
    localparam int MAXLEN = 511;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen6 = 1'b0, cen12 = 1'b0;
    logic [3:0] red = '0, green = '0, blue = '0;
    logic       LHBL = 1'b1, LVBL = 1'b1;
    logic       HS = ~HS_POL, VS = 1'b0;
    logic [3:0] vga_red, vga_green, vga_blue;
    logic       vga_hs, vga_vs, vga_blank;

    always #5 clk = ~clk;

    jt1943_scan2x #(.AW(AW), .HS_POL(HS_POL)) dut (
        .clk(clk), .rst(rst), .cen6(cen6), .cen12(cen12),
        .red(red), .green(green), .blue(blue),
        .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank)
    );

    int total = 0, bad = 0, out_idx = 0;
    logic [18:0] expq[$];
    localparam logic [18:0] RST_VEC = {12'h000, 1'b1, ~HS_POL, 1'b0};

    // model: a captured line is a list of {blank,rgb} words; j_m counts the
    // cen12 reads since the last swap, each replay lasting len reads
    logic [12:0] cap[$];
    logic [12:0] play[$];
    int          hs_len_m, cur_pulse, j_m;
    bit          armed_m, hs_prev_m;
    logic        vs_line_m;
    logic [18:0] prev_m;

    task automatic model_reset();
        cap.delete(); play.delete(); expq.delete();
        hs_len_m = 0; cur_pulse = 0; j_m = 0;
        armed_m = 0; hs_prev_m = 0; vs_line_m = 1'b0;
        prev_m = RST_VEC;
    endtask

    function automatic logic [18:0] read_now();
        int len, a;
        logic [12:0] w;
        len = play.size();
        if (len == 0 || j_m >= 2 * len) return {12'h000, 1'b1, ~HS_POL, vs_line_m};
        a = j_m % len;
        w = play[a];
        return {w[11:0], w[12], (a < hs_len_m) ? HS_POL : ~HS_POL, vs_line_m};
    endfunction

    task automatic model_tick(input bit is6, input logic [12:0] pix, input bit hs_act,
                              input logic vs);
        logic [18:0] r;
        int n;
        r = read_now();
        expq.push_back(prev_m);
        prev_m = r;
        if (is6 && hs_act && !hs_prev_m) begin
            play.delete();
            if (armed_m) begin
                n = (cap.size() > MAXLEN) ? MAXLEN : cap.size();
                for (int k = 0; k < n; k++) play.push_back(cap[k]);
            end
            hs_len_m  = (cur_pulse > MAXLEN) ? MAXLEN : cur_pulse;
            cur_pulse = 0;
            vs_line_m = vs;
            armed_m   = 1;
            cap.delete();
            j_m = 0;
        end else begin
            j_m++;
        end
        if (is6) begin
            hs_prev_m = hs_act;
            if (hs_act) cur_pulse++;
            if (cap.size() < MAXLEN + 1) cap.push_back(pix);
            else cap[MAXLEN] = pix;
        end
    endtask

    // one cen6 period: 4 clk, cen12 on phases 0 and 2
    task automatic cyc6(input logic [12:0] pix, input bit hs_act, input logic vs);
        logic [1:0] bsel;
        for (int ph = 0; ph < 4; ph++) begin
            @(negedge clk);
            cen6  = (ph == 0);
            cen12 = (ph == 0 || ph == 2);
            if (ph == 0) begin
                {red, green, blue} = pix[11:0];
                bsel = pix[12] ? 2'($urandom_range(1, 3)) : 2'b00;
                LHBL = ~bsel[0];
                LVBL = ~bsel[1];
                HS   = hs_act ? HS_POL : ~HS_POL;
                VS   = vs;
            end
            if (cen12) model_tick(ph == 0, pix, hs_act, VS);
        end
    endtask

    // mode 0: pixel = address, blank on [blo,bhi]; mode 1: random pixels
    task automatic send_line(input int npix, input int hsw, input logic vs, input int mode,
                             input int blo, input int bhi);
        logic [12:0] pix;
        logic        v;
        for (int p = 0; p < npix; p++) begin
            if (mode == 0) begin
                pix[11:0] = p[11:0];
                pix[12]   = (p >= blo && p <= bhi);
            end else begin
                pix = 13'($urandom);
            end
            v = (p == 0) ? VS : vs;
            cyc6(pix, p < hsw, v);
        end
    endtask

    task automatic do_reset(input int ncyc);
        logic [18:0] got;
        @(negedge clk);
        rst = 1'b1; cen6 = 1'b0; cen12 = 1'b0; HS = ~HS_POL;
        @(posedge clk);
        #1;
        got = {vga_red, vga_green, vga_blue, vga_blank, vga_hs, vga_vs};
        total++;
        if (got !== RST_VEC) begin
            bad++;
            $display("FAIL reset: got=%h want=%h", got, RST_VEC);
        end
        repeat (ncyc - 1) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    always @(posedge clk) begin
        if (cen12 && !rst) begin
            logic [18:0] got, e;
            #1;
            got = {vga_red, vga_green, vga_blue, vga_blank, vga_hs, vga_vs};
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL underflow at out %0d: got=%h want=<none>", out_idx, got);
            end else begin
                e = expq.pop_front();
                if (got !== e) begin
                    bad++;
                    if (bad < 30)
                        $display("FAIL pix out %0d: got=%h want=%h", out_idx, got, e);
                end
            end
            out_idx++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        model_reset();
        do_reset(3);
        // nominal, blanking and VS lines
        send_line(384, 32, 1'b0, 0, -1, -2);
        send_line(384, 32, 1'b0, 0, 0, 63);
        send_line(384, 32, 1'b1, 0, -1, -2);
        send_line(384, 32, 1'b0, 0, -1, -2);
        // overflow line then a line to replay it
        send_line(600, 32, 1'b0, 0, -1, -2);
        send_line(384, 20, 1'b0, 0, -1, -2);
        send_line(300, 20, 1'b1, 0, 100, 110);
        // short lines; the 5-pixel line swaps on the first-replay wrap
        send_line(10, 3, 1'b0, 1, 0, 0);
        send_line(10, 3, 1'b0, 1, 0, 0);
        send_line(5, 2, 1'b1, 1, 0, 0);
        send_line(10, 4, 1'b0, 1, 0, 0);
        send_line(10, 4, 1'b0, 1, 0, 0);
        // mid-line reset
        send_line(50, 6, 1'b0, 1, 0, 0);
        do_reset(3);
        send_line(40, 5, 1'b0, 1, 0, 0);
        send_line(40, 5, 1'b1, 1, 0, 0);
        send_line(40, 5, 1'b0, 1, 0, 0);
        // random lines
        for (int i = 0; i < 30; i++) begin
            int n, w;
            n = $urandom_range(6, 80);
            w = $urandom_range(1, n - 1);
            send_line(n, w, 1'($urandom), 1, 0, 0);
        end
        send_line(64, 8, 1'b0, 1, 0, 0);
        send_line(64, 8, 1'b0, 1, 0, 0);
        repeat (8) @(posedge clk);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
